// File: rtl/dcache_miss_ctrl.sv
// Load-side data-cache controller: hit return, MSHR miss tracking, BUS_LOAD issue,
// line fill through wr0 and halt drain.
module dcache_miss_ctrl #(
   parameter int unsigned MSHR_DEPTH = 4
) (
   input  logic        clock_i,
   input  logic        reset_ni,
   input  logic        ld_valid_i,
   input  logic [63:0] ld_addr_i,
   input  logic [4:0]  ld_id_i,
   output logic        ld_ready_o,
   output logic [6:0]  rd1_idx_o,
   output logic [21:0] rd1_tag_o,
   input  logic        rd1_valid_i,
   input  logic [63:0] rd1_data_i,
   output logic        ld_done_o,
   output logic [4:0]  ld_done_id_o,
   output logic [63:0] ld_done_data_o,
   output logic [1:0]  dmem_command_o,
   output logic [63:0] dmem_addr_o,
   input  logic [3:0]  dmem_response_i,
   input  logic [3:0]  dmem_tag_i,
   input  logic [63:0] dmem_data_i,
   output logic        wr0_en_o,
   output logic [6:0]  wr0_idx_o,
   output logic [21:0] wr0_tag_o,
   output logic [63:0] wr0_data_o,
   input  logic        halt_req_i,
   output logic        halt_ready_o
);

   localparam int unsigned IdxW = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;
   localparam logic [1:0] BusNone = 2'd0;
   localparam logic [1:0] BusLoad = 2'd1;

   logic [MSHR_DEPTH-1:0] valid_q, valid_d, issued_q, issued_d;
   logic [3:0]            mem_tag_q [MSHR_DEPTH];
   logic [3:0]            mem_tag_d [MSHR_DEPTH];
   logic [60:0]           addr_q    [MSHR_DEPTH];
   logic [60:0]           addr_d    [MSHR_DEPTH];
   logic [4:0]            id_q      [MSHR_DEPTH];
   logic [4:0]            id_d      [MSHR_DEPTH];

   logic        done_q, done_d, halt_ready_q, halt_ready_d;
   logic [4:0]  done_id_q, done_id_d;
   logic [63:0] done_data_q, done_data_d;

   logic            free_found, issue_found, ret_found;
   logic [IdxW-1:0] alloc_idx, issue_idx, ret_idx;
   logic            accept, hit, miss;
   logic            unused_offset;

   assign unused_offset = ^ld_addr_i[2:0];
   assign rd1_idx_o     = ld_addr_i[9:3];
   assign rd1_tag_o     = ld_addr_i[31:10];

   // Descending scans so the lowest matching index wins.
   always_comb begin
      free_found  = 1'b0;
      alloc_idx   = '0;
      issue_found = 1'b0;
      issue_idx   = '0;
      ret_found   = 1'b0;
      ret_idx     = '0;
      for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            alloc_idx  = IdxW'(i);
         end
         if (valid_q[i] && !issued_q[i]) begin
            issue_found = 1'b1;
            issue_idx   = IdxW'(i);
         end
         if (valid_q[i] && issued_q[i] && (dmem_tag_i != 4'd0) && (mem_tag_q[i] == dmem_tag_i)) begin
            ret_found = 1'b1;
            ret_idx   = IdxW'(i);
         end
      end
   end

   // A return cycle blocks acceptance so hits never collide with fills on ld_done.
   assign ld_ready_o = ~halt_req_i & free_found & (dmem_tag_i == 4'd0);
   assign accept     = ld_valid_i & ld_ready_o;
   assign hit        = accept & rd1_valid_i;
   assign miss       = accept & ~rd1_valid_i;

   assign dmem_command_o = issue_found ? BusLoad : BusNone;
   assign dmem_addr_o    = issue_found ? {addr_q[issue_idx], 3'b000} : 64'd0;

   assign wr0_en_o   = ret_found;
   assign wr0_idx_o  = ret_found ? addr_q[ret_idx][6:0] : 7'd0;
   assign wr0_tag_o  = ret_found ? addr_q[ret_idx][28:7] : 22'd0;
   assign wr0_data_o = dmem_data_i;

   always_comb begin
      valid_d     = valid_q;
      issued_d    = issued_q;
      mem_tag_d   = mem_tag_q;
      addr_d      = addr_q;
      id_d        = id_q;
      done_id_d   = done_id_q;
      done_data_d = done_data_q;
      if (issue_found && (dmem_response_i != 4'd0)) begin
         issued_d[issue_idx]  = 1'b1;
         mem_tag_d[issue_idx] = dmem_response_i;
      end
      if (ret_found) begin
         valid_d[ret_idx]  = 1'b0;
         issued_d[ret_idx] = 1'b0;
         done_id_d         = id_q[ret_idx];
         done_data_d       = dmem_data_i;
      end
      if (miss) begin
         valid_d[alloc_idx]  = 1'b1;
         issued_d[alloc_idx] = 1'b0;
         addr_d[alloc_idx]   = ld_addr_i[63:3];
         id_d[alloc_idx]     = ld_id_i;
      end
      if (hit) begin
         done_id_d   = ld_id_i;
         done_data_d = rd1_data_i;
      end
      done_d       = hit | ret_found;
      halt_ready_d = halt_req_i & ~(|valid_d) & ~done_d;
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         valid_q      <= '0;
         issued_q     <= '0;
         done_q       <= 1'b0;
         done_id_q    <= 5'd0;
         done_data_q  <= 64'd0;
         halt_ready_q <= 1'b0;
         for (int i = 0; i < MSHR_DEPTH; i++) begin
            mem_tag_q[i] <= 4'd0;
            addr_q[i]    <= 61'd0;
            id_q[i]      <= 5'd0;
         end
      end else begin
         valid_q      <= valid_d;
         issued_q     <= issued_d;
         mem_tag_q    <= mem_tag_d;
         addr_q       <= addr_d;
         id_q         <= id_d;
         done_q       <= done_d;
         done_id_q    <= done_id_d;
         done_data_q  <= done_data_d;
         halt_ready_q <= halt_ready_d;
      end
   end

   assign ld_done_o      = done_q;
   assign ld_done_id_o   = done_id_q;
   assign ld_done_data_o = done_data_q;
   assign halt_ready_o   = halt_ready_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: hit, miss, MSHR full, issue retry, halt, unmatched
// return and mid-miss reset.
module tb_dcache_miss_ctrl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ld_valid = 1'b0;
   logic [63:0] ld_addr = 64'd0;
   logic [4:0]  ld_id = 5'd0;
   logic        ld_ready;
   logic [6:0]  rd1_idx;
   logic [21:0] rd1_tag;
   logic        rd1_valid = 1'b0;
   logic [63:0] rd1_data = 64'd0;
   logic        ld_done;
   logic [4:0]  ld_done_id;
   logic [63:0] ld_done_data;
   logic [1:0]  dmem_command;
   logic [63:0] dmem_addr;
   logic [3:0]  dmem_response = 4'd0;
   logic [3:0]  dmem_tag = 4'd0;
   logic [63:0] dmem_data = 64'd0;
   logic        wr0_en;
   logic [6:0]  wr0_idx;
   logic [21:0] wr0_tag;
   logic [63:0] wr0_data;
   logic        halt_req = 1'b0;
   logic        halt_ready;

   int passed = 0;
   int total = 0;

   always #5 clock = ~clock;

   dcache_miss_ctrl #(.MSHR_DEPTH(4)) dut (
      .clock_i(clock), .reset_ni(reset_n),
      .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_id_i(ld_id), .ld_ready_o(ld_ready),
      .rd1_idx_o(rd1_idx), .rd1_tag_o(rd1_tag), .rd1_valid_i(rd1_valid), .rd1_data_i(rd1_data),
      .ld_done_o(ld_done), .ld_done_id_o(ld_done_id), .ld_done_data_o(ld_done_data),
      .dmem_command_o(dmem_command), .dmem_addr_o(dmem_addr),
      .dmem_response_i(dmem_response), .dmem_tag_i(dmem_tag), .dmem_data_i(dmem_data),
      .wr0_en_o(wr0_en), .wr0_idx_o(wr0_idx), .wr0_tag_o(wr0_tag), .wr0_data_o(wr0_data),
      .halt_req_i(halt_req), .halt_ready_o(halt_ready)
   );

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      tick();
      #1;
      total++; if (ld_done !== 1'b0) $display("FAIL rst_done: got %0b want 0", ld_done); else passed++;
      total++; if (ld_done_id !== 5'd0) $display("FAIL rst_id: got %0d want 0", ld_done_id); else passed++;
      total++; if (ld_done_data !== 64'd0) $display("FAIL rst_data: got %0h want 0", ld_done_data); else passed++;
      total++; if (halt_ready !== 1'b0) $display("FAIL rst_halt: got %0b want 0", halt_ready); else passed++;
      total++; if (dmem_command !== 2'd0) $display("FAIL rst_cmd: got %0d want 0", dmem_command); else passed++;
      total++; if (dmem_addr !== 64'd0) $display("FAIL rst_addr: got %0h want 0", dmem_addr); else passed++;
      total++; if (wr0_en !== 1'b0) $display("FAIL rst_wr0: got %0b want 0", wr0_en); else passed++;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_hit();
      ld_valid = 1'b1; ld_addr = 64'h408; ld_id = 5'd5; rd1_valid = 1'b1; rd1_data = 64'hDEAD_BEEF;
      #1;
      total++; if (rd1_idx !== 7'h01) $display("FAIL hit_idx: got %0h want 1", rd1_idx); else passed++;
      total++; if (rd1_tag !== 22'h001) $display("FAIL hit_tag: got %0h want 1", rd1_tag); else passed++;
      total++; if (ld_ready !== 1'b1) $display("FAIL hit_ready: got %0b want 1", ld_ready); else passed++;
      tick();
      ld_valid = 1'b0; rd1_valid = 1'b0;
      #1;
      total++; if (ld_done !== 1'b1) $display("FAIL hit_done: got %0b want 1", ld_done); else passed++;
      total++; if (ld_done_id !== 5'd5) $display("FAIL hit_id: got %0d want 5", ld_done_id); else passed++;
      total++; if (ld_done_data !== 64'hDEAD_BEEF) $display("FAIL hit_data: got %0h want deadbeef", ld_done_data); else passed++;
      total++; if (dmem_command !== 2'd0) $display("FAIL hit_nocmd: got %0d want 0", dmem_command); else passed++;
      tick();
      #1;
      total++; if (ld_done !== 1'b0) $display("FAIL hit_done_clr: got %0b want 0", ld_done); else passed++;
   endtask

   task automatic test_miss();
      ld_valid = 1'b1; ld_addr = 64'h1000; ld_id = 5'd3; rd1_valid = 1'b0;
      tick();
      ld_valid = 1'b0; dmem_response = 4'd3;
      #1;
      total++; if (dmem_command !== 2'd1) $display("FAIL miss_cmd: got %0d want 1", dmem_command); else passed++;
      total++; if (dmem_addr !== 64'h1000) $display("FAIL miss_addr: got %0h want 1000", dmem_addr); else passed++;
      tick();
      dmem_response = 4'd0;
      #1;
      total++; if (dmem_command !== 2'd0) $display("FAIL miss_cmd_off: got %0d want 0", dmem_command); else passed++;
      for (int i = 0; i < 9; i++) tick();
      dmem_tag = 4'd3; dmem_data = 64'h55;
      #1;
      total++; if (wr0_en !== 1'b1) $display("FAIL miss_wr0_en: got %0b want 1", wr0_en); else passed++;
      total++; if (wr0_idx !== 7'h00) $display("FAIL miss_wr0_idx: got %0h want 0", wr0_idx); else passed++;
      total++; if (wr0_tag !== 22'h004) $display("FAIL miss_wr0_tag: got %0h want 4", wr0_tag); else passed++;
      total++; if (wr0_data !== 64'h55) $display("FAIL miss_wr0_data: got %0h want 55", wr0_data); else passed++;
      total++; if (ld_done !== 1'b0) $display("FAIL miss_early_done: got %0b want 0", ld_done); else passed++;
      tick();
      dmem_tag = 4'd0;
      #1;
      total++; if (ld_done !== 1'b1) $display("FAIL miss_done: got %0b want 1", ld_done); else passed++;
      total++; if (ld_done_id !== 5'd3) $display("FAIL miss_id: got %0d want 3", ld_done_id); else passed++;
      total++; if (ld_done_data !== 64'h55) $display("FAIL miss_data: got %0h want 55", ld_done_data); else passed++;
      total++; if (wr0_en !== 1'b0) $display("FAIL miss_wr0_clr: got %0b want 0", wr0_en); else passed++;
      tick();
   endtask

   task automatic test_mshr_full();
      int tags [4] = '{1, 2, 4, 6};
      int ids  [4] = '{0, 1, 3, 9};
      int idxs [4] = '{0, 1, 3, 5};
      for (int k = 0; k < 4; k++) begin
         ld_valid = 1'b1; ld_addr = 64'h2000 + 64'(8 * k); ld_id = 5'(k); rd1_valid = 1'b0;
         #1;
         total++; if (ld_ready !== 1'b1) $display("FAIL full_fill_ready%0d: got %0b want 1", k, ld_ready); else passed++;
         tick();
      end
      ld_addr = 64'h3028; ld_id = 5'd9;
      #1;
      total++; if (ld_ready !== 1'b0) $display("FAIL full_ready: got %0b want 0", ld_ready); else passed++;
      for (int k = 0; k < 4; k++) begin
         dmem_response = 4'(k + 1);
         #1;
         total++; if (dmem_addr !== 64'h2000 + 64'(8 * k)) $display("FAIL full_issue%0d: got %0h want %0h", k, dmem_addr, 64'h2000 + 64'(8 * k)); else passed++;
         tick();
      end
      dmem_response = 4'd0; dmem_tag = 4'd3; dmem_data = 64'hA2;
      #1;
      total++; if (wr0_idx !== 7'd2) $display("FAIL full_ret_idx: got %0d want 2", wr0_idx); else passed++;
      total++; if (ld_ready !== 1'b0) $display("FAIL full_ret_ready: got %0b want 0", ld_ready); else passed++;
      tick();
      dmem_tag = 4'd0;
      #1;
      total++; if (ld_ready !== 1'b1) $display("FAIL full_freed_ready: got %0b want 1", ld_ready); else passed++;
      total++; if (ld_done_id !== 5'd2) $display("FAIL full_done_id: got %0d want 2", ld_done_id); else passed++;
      tick();
      ld_valid = 1'b0;
      #1;
      total++; if (ld_ready !== 1'b0) $display("FAIL full_again: got %0b want 0", ld_ready); else passed++;
      total++; if (dmem_addr !== 64'h3028) $display("FAIL full_new_addr: got %0h want 3028", dmem_addr); else passed++;
      dmem_response = 4'd6;
      tick();
      dmem_response = 4'd0;
      for (int k = 0; k < 4; k++) begin
         dmem_tag = 4'(tags[k]); dmem_data = 64'(100 + k);
         #1;
         total++; if (wr0_idx !== 7'(idxs[k])) $display("FAIL drain_idx%0d: got %0d want %0d", k, wr0_idx, idxs[k]); else passed++;
         tick();
         dmem_tag = 4'd0;
         #1;
         total++; if (ld_done_id !== 5'(ids[k])) $display("FAIL drain_id%0d: got %0d want %0d", k, ld_done_id, ids[k]); else passed++;
      end
      tick();
   endtask

   task automatic test_retry();
      ld_valid = 1'b1; ld_addr = 64'h4010; ld_id = 5'd7; rd1_valid = 1'b0;
      tick();
      ld_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         dmem_response = (c == 3) ? 4'd5 : 4'd0;
         #1;
         total++; if (dmem_command !== 2'd1) $display("FAIL retry_cmd%0d: got %0d want 1", c, dmem_command); else passed++;
         total++; if (dmem_addr !== 64'h4010) $display("FAIL retry_addr%0d: got %0h want 4010", c, dmem_addr); else passed++;
         tick();
      end
      dmem_response = 4'd0;
      #1;
      total++; if (dmem_command !== 2'd0) $display("FAIL retry_done_cmd: got %0d want 0", dmem_command); else passed++;
      dmem_tag = 4'd5; dmem_data = 64'h5;
      tick();
      dmem_tag = 4'd0;
      #1;
      total++; if (ld_done_id !== 5'd7 || ld_done !== 1'b1) $display("FAIL retry_done: got %0b/%0d want 1/7", ld_done, ld_done_id); else passed++;
      tick();
   endtask

   task automatic test_halt();
      ld_valid = 1'b1; ld_addr = 64'h5000; ld_id = 5'd1; rd1_valid = 1'b0;
      tick();
      ld_addr = 64'h5008; ld_id = 5'd2; dmem_response = 4'd1;
      tick();
      ld_addr = 64'h5FF8; ld_id = 5'd30; rd1_valid = 1'b1; rd1_data = 64'h77;
      halt_req = 1'b1; dmem_response = 4'd2;
      #1;
      total++; if (ld_ready !== 1'b0) $display("FAIL halt_ready_c2: got %0b want 0", ld_ready); else passed++;
      tick();
      dmem_response = 4'd0; dmem_tag = 4'd1; dmem_data = 64'h11;
      #1;
      total++; if (ld_done !== 1'b0) $display("FAIL halt_nohit: got %0b want 0", ld_done); else passed++;
      tick();
      dmem_tag = 4'd2; dmem_data = 64'h22;
      #1;
      total++; if (ld_ready !== 1'b0) $display("FAIL halt_ready_c4: got %0b want 0", ld_ready); else passed++;
      total++; if (ld_done_id !== 5'd1) $display("FAIL halt_done1: got %0d want 1", ld_done_id); else passed++;
      tick();
      dmem_tag = 4'd0;
      #1;
      total++; if (ld_done_data !== 64'h22 || ld_done_id !== 5'd2) $display("FAIL halt_done2: got %0h/%0d want 22/2", ld_done_data, ld_done_id); else passed++;
      total++; if (ld_ready !== 1'b0) $display("FAIL halt_ready_c5: got %0b want 0", ld_ready); else passed++;
      total++; if (halt_ready !== 1'b0) $display("FAIL halt_early: got %0b want 0", halt_ready); else passed++;
      tick();
      #1;
      total++; if (halt_ready !== 1'b1) $display("FAIL halt_rise: got %0b want 1", halt_ready); else passed++;
      total++; if (ld_done !== 1'b0) $display("FAIL halt_no_hitdone: got %0b want 0", ld_done); else passed++;
      tick();
      #1;
      total++; if (halt_ready !== 1'b1) $display("FAIL halt_hold: got %0b want 1", halt_ready); else passed++;
      halt_req = 1'b0; ld_valid = 1'b0; rd1_valid = 1'b0;
      tick();
      #1;
      total++; if (halt_ready !== 1'b0) $display("FAIL halt_clear: got %0b want 0", halt_ready); else passed++;
      tick();
   endtask

   task automatic test_unmatched_reset();
      dmem_tag = 4'd7; dmem_data = 64'h99;
      #1;
      total++; if (wr0_en !== 1'b0) $display("FAIL unmatched_wr0: got %0b want 0", wr0_en); else passed++;
      tick();
      dmem_tag = 4'd0;
      ld_valid = 1'b1; ld_addr = 64'h6000; ld_id = 5'd4; rd1_valid = 1'b0;
      #1;
      total++; if (ld_done !== 1'b0) $display("FAIL unmatched_done: got %0b want 0", ld_done); else passed++;
      tick();
      ld_addr = 64'h6008; ld_id = 5'd5; dmem_response = 4'd9;
      tick();
      ld_valid = 1'b0; dmem_response = 4'd0;
      #1;
      total++; if (dmem_command !== 2'd1) $display("FAIL prereset_cmd: got %0d want 1", dmem_command); else passed++;
      reset_n = 1'b0;
      #1;
      total++; if (dmem_command !== 2'd0 || dmem_addr !== 64'd0) $display("FAIL reset_cmd: got %0d/%0h want 0/0", dmem_command, dmem_addr); else passed++;
      total++; if (ld_done !== 1'b0 || halt_ready !== 1'b0) $display("FAIL reset_done: got %0b/%0b want 0/0", ld_done, halt_ready); else passed++;
      total++; if (ld_done_id !== 5'd0) $display("FAIL reset_id: got %0d want 0", ld_done_id); else passed++;
      tick();
      reset_n = 1'b1;
      tick();
      dmem_tag = 4'd9; dmem_data = 64'h1234;
      #1;
      total++; if (wr0_en !== 1'b0) $display("FAIL stale_wr0: got %0b want 0", wr0_en); else passed++;
      tick();
      dmem_tag = 4'd0;
      #1;
      total++; if (ld_done !== 1'b0) $display("FAIL stale_done: got %0b want 0", ld_done); else passed++;
      total++; if (ld_ready !== 1'b1) $display("FAIL stale_ready: got %0b want 1", ld_ready); else passed++;
   endtask

   initial begin
      test_reset();
      test_hit();
      test_miss();
      test_mshr_full();
      test_retry();
      test_halt();
      test_unmatched_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
